// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder pipeline: mode encodings and
// a helper that turns an approximation width into a low-bit mask.
`timescale 1ns/1ps
package approx_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOA   = 2'd1,
    MODE_TRUNC = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Mask with the low k bits set; k may be 0 (empty mask) up to 32.
  function automatic logic [32:0] low_mask(input int unsigned k);
    logic [32:0] one;
    one = 33'd1;
    return (one << k) - one;
  endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational approximate adder (exact / lower-part-OR / truncated) with an
// exact reference sum and the absolute error between the two.
`timescale 1ns/1ps
module approx_add_core
  import approx_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 3
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  mode_e            mode_i,
  output logic [WIDTH:0]   sum_o,
  output logic [WIDTH:0]   err_o
);

  // Index of the top approximated bit; clamped so K=0 never forms a[-1].
  localparam int KI = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
  localparam logic [32:0] MASK_FULL = low_mask(APPROX_BITS);
  localparam logic [WIDTH:0] LOW_MASK = MASK_FULL[WIDTH:0];

  logic [WIDTH:0] exact_sum;
  logic [WIDTH:0] a_hi;
  logic [WIDTH:0] b_hi;
  logic [WIDTH:0] hi_sum;
  logic [WIDTH:0] low_or;
  logic [WIDTH:0] approx_sum;
  logic           carry_in;

  // NOTE: every signal assigned in always_comb gets a value before any branch,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    exact_sum  = {1'b0, a_i} + {1'b0, b_i};
    a_hi       = {1'b0, a_i} >> APPROX_BITS;
    b_hi       = {1'b0, b_i} >> APPROX_BITS;
    low_or     = ({1'b0, a_i} | {1'b0, b_i}) & LOW_MASK;
    carry_in   = 1'b0;
    approx_sum = exact_sum;

    if ((mode_i == MODE_LOA) && (APPROX_BITS > 0)) begin
      carry_in = a_i[KI] & b_i[KI];
    end
    hi_sum = a_hi + b_hi + {{WIDTH{1'b0}}, carry_in};

    case (mode_i)
      MODE_LOA:   approx_sum = (hi_sum << APPROX_BITS) | low_or;
      MODE_TRUNC: approx_sum = hi_sum << APPROX_BITS;
      default:    approx_sum = exact_sum;
    endcase

    sum_o = approx_sum;
    err_o = (approx_sum >= exact_sum) ? (approx_sum - exact_sum)
                                      : (exact_sum - approx_sum);
  end

endmodule

// File: rtl/approx_add_pipe.sv
// Two-stage elastic pipeline around approx_add_core, with running error
// statistics updated on each output handshake.
`timescale 1ns/1ps
module approx_add_pipe
  import approx_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 3,
  parameter int SUM_W       = 24,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_err,
  input  logic             clear_stats,
  output logic [SUM_W-1:0] stat_sum_err,
  output logic [WIDTH:0]   stat_max_err,
  output logic [CNT_W-1:0] stat_count
);

  logic             rdy_q;
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  mode_e            s1_mode_q;
  logic             s2_valid_q;
  logic [WIDTH:0]   s2_sum_q;
  logic [WIDTH:0]   s2_err_q;

  logic [WIDTH:0]   core_sum;
  logic [WIDTH:0]   core_err;
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             out_hs;

  logic [SUM_W-1:0] stat_sum_q, stat_sum_d;
  logic [WIDTH:0]   stat_max_q, stat_max_d;
  logic [CNT_W-1:0] stat_cnt_q, stat_cnt_d;
  logic [SUM_W:0]   sum_ext;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  // rdy_q keeps in_ready low in reset and for the cycle before the first edge.
  assign in_ready  = rdy_q && s1_adv;
  assign accept    = in_valid && in_ready;
  assign out_hs    = s2_valid_q && out_ready;

  assign out_valid    = s2_valid_q;
  assign out_sum      = s2_sum_q;
  assign out_err      = s2_err_q;
  assign stat_sum_err = stat_sum_q;
  assign stat_max_err = stat_max_q;
  assign stat_count   = stat_cnt_q;

  approx_add_core #(
    .WIDTH       (WIDTH),
    .APPROX_BITS (APPROX_BITS)
  ) u_core (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .mode_i (s1_mode_q),
    .sum_o  (core_sum),
    .err_o  (core_err)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: datapath registers are reset as well, so out_sum/out_err read zero
  // during reset instead of whatever was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_EXACT;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_err_q   <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_adv) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_a_q    <= in_a;
          s1_b_q    <= in_b;
          s1_mode_q <= mode_e'(in_mode);
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sum_q <= core_sum;
          s2_err_q <= core_err;
        end
      end
    end
  end

  // Clear wins over a same-cycle handshake; that sample is simply not counted.
  always_comb begin
    stat_sum_d = stat_sum_q;
    stat_max_d = stat_max_q;
    stat_cnt_d = stat_cnt_q;
    sum_ext    = {1'b0, stat_sum_q} + (SUM_W+1)'(s2_err_q);
    if (clear_stats) begin
      stat_sum_d = '0;
      stat_max_d = '0;
      stat_cnt_d = '0;
    end else if (out_hs) begin
      stat_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      stat_cnt_d = (&stat_cnt_q) ? stat_cnt_q : stat_cnt_q + CNT_W'(1);
      if (s2_err_q > stat_max_q) begin
        stat_max_d = s2_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sum_q <= '0;
      stat_max_q <= '0;
      stat_cnt_q <= '0;
    end else begin
      stat_sum_q <= stat_sum_d;
      stat_max_q <= stat_max_d;
      stat_cnt_q <= stat_cnt_d;
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Scoreboard bench for approx_add_pipe (WIDTH=8, K=3): directed vectors with
// hand-computed results, backpressure, statistics, clear and mid-stream reset.
`timescale 1ns/1ps
module tb_approx_add_pipe;
  import approx_pkg::*;

  localparam int WIDTH = 8;
  localparam int K     = 3;
  localparam int SUM_W = 24;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [WIDTH:0]   out_err;
  logic             clear_stats;
  logic [SUM_W-1:0] stat_sum_err;
  logic [WIDTH:0]   stat_max_err;
  logic [CNT_W-1:0] stat_count;

  typedef struct packed {
    logic [WIDTH:0] sum;
    logic [WIDTH:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  approx_add_pipe #(
    .WIDTH       (WIDTH),
    .APPROX_BITS (K),
    .SUM_W       (SUM_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_err      (out_err),
    .clear_stats  (clear_stats),
    .stat_sum_err (stat_sum_err),
    .stat_max_err (stat_max_err),
    .stat_count   (stat_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Called between a rising and the following falling edge; returns just after
  // the accepting edge with in_valid dropped.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                      input logic [8:0] es, input logic [8:0] ee, output int waits);
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    in_valid = 1'b1;
    exp_q.push_back(exp_t'({es, ee}));
    waits = 0;
    @(negedge clk);
    while (!in_ready) begin
      waits++;
      if (waits > 200) begin
        fail_now("accept_timeout");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (exp_q.size() != 0) fail_now(name);
  endtask

  task automatic check_stats(input string tag, input logic [23:0] s, input logic [8:0] mx,
                             input logic [15:0] c);
    check({tag, "_sum"},   stat_sum_err, s);
    check({tag, "_max"},   stat_max_err, mx);
    check({tag, "_count"}, stat_count,   c);
  endtask

  // Monitor: pops on handshake, checks the head entry is held while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("out_sum", out_sum, e.sum);
          check("out_err", out_err, e.err);
        end else begin
          check("hold_sum", out_sum, exp_q[0].sum);
          check("hold_err", out_err, exp_q[0].err);
        end
      end
    end
  end

  initial begin
    int w;
    logic [7:0] rdy_pat;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_mode     = 2'd0;
    out_ready   = 1'b1;
    clear_stats = 1'b0;
    rst_n       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum",   out_sum,   0);
    check("rst_out_err",   out_err,   0);
    check_stats("rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("in_ready_after_edge", in_ready, 1);

    // TRUNC and EXACT back to back, then LOA with a latency check.
    send(8'hFF, 8'hFF, 2'd2, 9'h1F0, 9'd14, w);
    send(8'hFF, 8'h01, 2'd0, 9'h100, 9'd0, w);
    check("back_to_back_waits", w, 0);
    repeat (3) @(posedge clk);
    #1;
    send(8'h07, 8'h01, 2'd1, 9'h007, 9'd1, w);
    check("lat_not_yet_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid_second_edge", out_valid, 1);
    drain("drain_stats");
    check_stats("stats3", 24'd15, 9'd14, 16'd3);

    // Clear coinciding with a handshake: statistics zeroed, result still delivered.
    send(8'h0F, 8'h01, 2'd2, 9'h008, 9'd8, w);
    @(posedge clk);
    #1;
    check("clr_out_valid", out_valid, 1);
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    check_stats("clear", 0, 0, 0);
    check("clr_consumed", exp_q.size(), 0);

    // Backpressure: two accepted, third waits until out_ready returns.
    out_ready = 1'b0;
    send(8'h0C, 8'h04, 2'd1, 9'h014, 9'd4, w);
    send(8'h85, 8'h73, 2'd2, 9'h0F0, 9'd8, w);
    check("bp_in_ready_low", in_ready, 0);
    fork
      begin
        int w3;
        send(8'hAA, 8'h55, 2'd3, 9'h0FF, 9'd0, w3);
      end
    join_none
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("bp_stalled_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    drain("drain_bp");
    repeat (2) @(posedge clk);
    #1;
    check_stats("bp", 24'd12, 9'd8, 16'd3);

    // Burst under an irregular out_ready pattern.
    rdy_pat = 8'b1011_0010;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          out_ready = rdy_pat[i % 8];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join_none
    send(8'h80, 8'h80, 2'd0, 9'h100, 9'd0, w);
    send(8'hFF, 8'hFF, 2'd1, 9'h1FF, 9'd1, w);
    send(8'h03, 8'h04, 2'd1, 9'h007, 9'd0, w);
    send(8'hA5, 8'h5A, 2'd2, 9'h0F8, 9'd7, w);
    drain("drain_burst");
    repeat (20) @(posedge clk);
    #1;
    out_ready = 1'b1;
    check_stats("burst", 24'd20, 9'd8, 16'd7);

    // Reset with both stages full: nothing in flight may survive.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 2'd0, 9'h033, 9'd0, w);
    send(8'h44, 8'h11, 2'd1, 9'h055, 9'd0, w);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready",  in_ready,  0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready",  in_ready,  0);
    check_stats("midrst", 0, 0, 0);
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h10, 8'h20, 2'd0, 9'h030, 9'd0, w);
    drain("drain_after_rst");
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_count", stat_count, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
